// File: rtl/onehot_decoder_seq.sv
// Sequenced 3-to-8 decoder: codes arrive over valid/ready, queue in a small FIFO,
// and replay as one-hot pulses of HOLD_CYCLES followed by GAP_CYCLES of all-zero.
module onehot_decoder_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 code,
    output logic [7:0]                 Y,
    output logic                       out_valid,
    output logic [2:0]                 out_code,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      y_d;
    logic            ov_d;
    logic [2:0]      oc_d;
    logic            push, pop, load;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [2:0]      mem [DEPTH];
    logic [2:0]      head;

    assign in_ready = (level != LW'(DEPTH)) & ~clr;
    assign push     = in_valid & in_ready;
    assign head     = mem[rd_ptr];
    assign busy     = (state_q != IDLE) | (level != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= code;
        end
    end

    // Full FIFO refuses input even if a pop happens this cycle (no pass-through).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = Y;
        ov_d    = out_valid;
        oc_d    = out_code;
        load    = 1'b0;
        pop     = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            y_d     = '0;
            ov_d    = 1'b0;
            oc_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (level != '0) load = 1'b1;
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        y_d     = '0;
                        ov_d    = 1'b0;
                        oc_d    = '0;
                        cnt_d   = 8'(GAP_CYCLES - 1);
                        state_d = GAP;
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (level != '0) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            // Pop and output load share one edge, so GAP->HOLD needs no idle cycle.
            if (load) begin
                pop     = 1'b1;
                y_d     = 8'd1 << head;
                oc_d    = head;
                ov_d    = 1'b1;
                cnt_d   = 8'(HOLD_CYCLES - 1);
                state_d = HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            Y         <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            Y         <= y_d;
            out_valid <= ov_d;
            out_code  <= oc_d;
        end
    end

endmodule
